// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions used by the register-file debug readout.
package lc3_pkg;
    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        READ,
        SEND0,
        SEND1,
        DONE
    } dump_state_e;
endpackage

// File: rtl/reg_dump_unit.sv
// Streams the LC-3 register file out as (index, value) beats, reading one
// even/odd register pair per grant of the file's two asynchronous read ports.
module reg_dump_unit #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              rf_req,
    input  logic              rf_gnt,
    output logic [AW-1:0]     sr1_addr,
    output logic [AW-1:0]     sr2_addr,
    input  logic [DATA_W-1:0] sr1_in,
    input  logic [DATA_W-1:0] sr2_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [AW-1:0]     out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    import lc3_pkg::*;

    dump_state_e       r_state;
    dump_state_e       w_next;
    logic [AW-1:0]     r_k;
    logic [DATA_W-1:0] r_buf0;
    logic [DATA_W-1:0] r_buf1;

    logic [AW-1:0]     w_even_idx;
    logic [AW-1:0]     w_odd_idx;
    logic              w_last_pair;
    logic              w_hs;

    assign w_even_idx  = AW'({r_k, 1'b0});
    assign w_odd_idx   = w_even_idx | AW'(1);
    assign w_last_pair = (r_k == AW'(NUM_REGS / 2 - 1));
    assign w_hs        = out_valid && out_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start)  w_next = REQ;
            REQ:     if (rf_gnt) w_next = READ;
            // A grant lost mid-read re-requests the same pair.
            READ:    w_next = rf_gnt ? SEND0 : REQ;
            SEND0:   if (w_hs)   w_next = SEND1;
            SEND1:   if (w_hs)   w_next = w_last_pair ? DONE : REQ;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // All outputs decode from registered state only, so none depends
    // combinationally on out_ready or rf_gnt.
    always_comb begin
        rf_req    = 1'b0;
        sr1_addr  = '0;
        sr2_addr  = '0;
        out_valid = 1'b0;
        out_data  = '0;
        out_idx   = '0;
        out_last  = 1'b0;
        busy      = (r_state != IDLE);
        done      = 1'b0;
        case (r_state)
            REQ:  rf_req = 1'b1;
            READ: begin
                rf_req   = 1'b1;
                sr1_addr = w_even_idx;
                sr2_addr = w_odd_idx;
            end
            SEND0: begin
                out_valid = 1'b1;
                out_data  = r_buf0;
                out_idx   = w_even_idx;
            end
            SEND1: begin
                out_valid = 1'b1;
                out_data  = r_buf1;
                out_idx   = w_odd_idx;
                out_last  = w_last_pair;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_buf0  <= '0;
            r_buf1  <= '0;
        end else if (abort) begin
            r_state <= IDLE;
            r_k     <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start)
                r_k <= '0;
            // Both halves of a pair are captured on the same edge.
            if (r_state == READ && rf_gnt) begin
                r_buf0 <= sr1_in;
                r_buf1 <= sr2_in;
            end
            if (r_state == SEND1 && w_hs && !w_last_pair)
                r_k <= r_k + AW'(1);
        end
    end
endmodule

// File: tb/tb_reg_dump_unit.sv
// Bench for reg_dump_unit: behavioural LC-3 register file plus a beat scoreboard.
module tb_reg_dump_unit;
    localparam int DW = 16;
    localparam int NR = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset, start, abort, rf_gnt, out_ready;
    logic          rf_req, out_valid, out_last, busy, done;
    logic [AW-1:0] sr1_addr, sr2_addr, out_idx;
    logic [DW-1:0] sr1_in, sr2_in, out_data;

    // bench-side register file and write port
    logic [DW-1:0] rf [NR];
    logic          ld_reg;
    logic [AW-1:0] dr_addr;
    logic [DW-1:0] from_bus;
    logic [DW-1:0] shadow [NR];

    typedef struct packed {
        logic          last;
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
    } beat_t;
    beat_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (ld_reg) rf[dr_addr] <= from_bus;
    assign sr1_in = rf[sr1_addr];
    assign sr2_in = rf[sr2_addr];

    reg_dump_unit #(.DATA_W(DW), .NUM_REGS(NR)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .rf_req(rf_req), .rf_gnt(rf_gnt),
        .sr1_addr(sr1_addr), .sr2_addr(sr2_addr),
        .sr1_in(sr1_in), .sr2_in(sr2_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
        .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // scoreboard + hold-stability monitor, sampled on the falling edge
    logic          hold_pend = 1'b0;
    logic [DW-1:0] hold_data;
    logic [AW-1:0] hold_idx;
    logic          hold_last;
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (hold_pend) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'(hold_data));
            chk("hold_idx", 32'(out_idx), 32'(hold_idx));
            chk("hold_last", 32'(out_last), 32'(hold_last));
        end
        hold_pend = out_valid && !out_ready && !reset && !abort;
        hold_data = out_data;
        hold_idx  = out_idx;
        hold_last = out_last;
        if (out_valid && out_ready && !reset && !abort) begin
            if (exp_q.size() == 0) begin
                chk("beat_unexpected_idx", 32'(out_idx), 32'hFFFF_FFFF);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk("beat_idx", 32'(out_idx), 32'(e.idx));
                chk("beat_data", 32'(out_data), 32'(e.data));
                chk("beat_last", 32'(out_last), 32'(e.last));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beats(input int n);
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.idx  = AW'(i);
            b.data = shadow[i];
            b.last = (i == NR - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int base);
        int n = 0;
        while (done_cnt == base && n < 400) begin
            step();
            n++;
        end
        repeat (3) step();
        chk(tag, 32'(done_cnt - base), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_qempty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_req"}, 32'(rf_req), 32'd0);
        chk({tag, "_addrs"}, 32'({sr1_addr, sr2_addr}), 32'd0);
        chk({tag, "_data"}, 32'(out_data), 32'd0);
        chk({tag, "_idx_last"}, 32'({out_idx, out_last}), 32'd0);
    endtask

    initial begin
        int base, n;
        logic hit;
        reset = 1'b1; start = 1'b0; abort = 1'b0; rf_gnt = 1'b1; out_ready = 1'b1;
        ld_reg = 1'b0; dr_addr = '0; from_bus = '0;
        repeat (2) step();
        check_all_zero("reset");
        reset = 1'b0;

        // preload Rn = 0x1000 + n through the write port
        for (int i = 0; i < NR; i++) begin
            ld_reg = 1'b1; dr_addr = AW'(i); from_bus = DW'(16'h1000 + i);
            shadow[i] = DW'(16'h1000 + i);
            step();
        end
        ld_reg = 1'b0;
        step();

        // T1: full-speed dump with cycle-exact latency
        base = done_cnt;
        push_beats(NR);
        pulse_start();
        for (int c = 1; c <= 18; c++) begin
            if (c == 1)  chk("t1_req_c1", 32'({rf_req, busy}), 32'b11);
            if (c == 2)  chk("t1_addr_c2", 32'({sr1_addr, sr2_addr}), 32'({3'd0, 3'd1}));
            if (c == 3)  chk("t1_valid_c3", 32'({out_valid, out_idx}), 32'({1'b1, 3'd0}));
            if (c == 15) chk("t1_nolast_c15", 32'(out_last), 32'd0);
            if (c == 16) chk("t1_last_c16", 32'({out_valid, out_last, out_idx}), 32'({2'b11, 3'd7}));
            if (c == 17) chk("t1_done_c17", 32'(done), 32'd1);
            if (c == 18) chk("t1_idle_c18", 32'({busy, done}), 32'd0);
            if (c < 18) step();
        end
        step();
        chk("t1_done_once", 32'(done_cnt - base), 32'd1);
        chk("t1_qempty", 32'(exp_q.size()), 32'd0);

        // T2: out_ready toggles every cycle
        base = done_cnt;
        push_beats(NR);
        pulse_start();
        n = 0;
        while (done_cnt == base && n < 300) begin
            out_ready = ~out_ready;
            step();
            n++;
        end
        out_ready = 1'b1;
        wait_done("t2_done", base);

        // T3: grant withheld for 5 cycles, then lost in READ of pair 2
        base = done_cnt;
        push_beats(NR);
        rf_gnt = 1'b0;
        pulse_start();
        repeat (5) step();
        chk("t3_req_wait", 32'({rf_req, busy, out_valid}), 32'b110);
        rf_gnt = 1'b1;
        hit = 1'b0;
        n = 0;
        while (!hit && n < 100) begin
            if (sr1_addr == 3'd4) begin
                rf_gnt = 1'b0;
                step();
                chk("t3_rereq", 32'({rf_req, sr1_addr, out_valid}), 32'({1'b1, 3'd0, 1'b0}));
                rf_gnt = 1'b1;
                hit = 1'b1;
            end else begin
                step();
                n++;
            end
        end
        chk("t3_read_k2_seen", 32'(hit), 32'd1);
        wait_done("t3_done", base);

        // T4: abort during SEND1 of pair 1 (idx 3)
        base = done_cnt;
        push_beats(3);
        pulse_start();
        hit = 1'b0;
        n = 0;
        while (!hit && n < 100) begin
            if (out_valid && out_idx == 3'd3) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                chk("t4_abort", 32'({out_valid, busy}), 32'd0);
                hit = 1'b1;
            end else begin
                step();
                n++;
            end
        end
        chk("t4_send1_seen", 32'(hit), 32'd1);
        repeat (4) step();
        chk("t4_no_done", 32'(done_cnt - base), 32'd0);
        chk("t4_qempty", 32'(exp_q.size()), 32'd0);
        push_beats(NR);
        pulse_start();
        wait_done("t4_redump", base);

        // T5: second start ignored, reset during READ of pair 3
        push_beats(6);
        pulse_start();
        repeat (4) step();
        pulse_start();
        hit = 1'b0;
        n = 0;
        while (!hit && n < 100) begin
            if (sr1_addr == 3'd6) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                check_all_zero("t5_reset");
                hit = 1'b1;
            end else begin
                step();
                n++;
            end
        end
        chk("t5_read_k3_seen", 32'(hit), 32'd1);
        repeat (3) step();
        chk("t5_stay_idle", 32'({busy, rf_req}), 32'd0);
        chk("t5_qempty", 32'(exp_q.size()), 32'd0);

        // T6: write R5 on the capture edge of pair 2 -> old value streamed
        base = done_cnt;
        push_beats(NR);
        pulse_start();
        hit = 1'b0;
        n = 0;
        while (!hit && n < 100) begin
            if (sr1_addr == 3'd4) begin
                ld_reg = 1'b1; dr_addr = 3'd5; from_bus = 16'hF000;
                step();
                ld_reg = 1'b0;
                shadow[5] = 16'hF000;
                hit = 1'b1;
            end else begin
                step();
                n++;
            end
        end
        chk("t6_read_k2_seen", 32'(hit), 32'd1);
        wait_done("t6_done", base);
        base = done_cnt;
        push_beats(NR);
        pulse_start();
        wait_done("t6_redump", base);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
